// File: rtl/led_pattern_shifter_pkg.sv
// Shared constants for the LED pattern shifter: mode and direction encodings.
package led_pattern_pkg;

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Every mode except hold advances the pattern on a tick.
  function automatic logic is_step_mode(input logic [1:0] mode);
    return mode != MODE_HOLD;
  endfunction

endpackage

// File: rtl/led_pattern_shifter_if.sv
// Control/status bundle of the LED pattern shifter.
// master: the controller driving mode/load/duty; slave: the shifter itself.
interface led_pattern_shifter_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DUTY_W = 4
);
  logic              en;
  logic [1:0]        mode;
  logic              dir;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [DUTY_W-1:0] duty;
  logic [WIDTH-1:0]  led;
  logic              step;
  logic              wrap;

  modport master (
    output en, mode, dir, load, load_val, duty,
    input  led, step, wrap
  );

  modport slave (
    input  en, mode, dir, load, load_val, duty,
    output led, step, wrap
  );
endinterface

// File: rtl/led_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count as the step tick.
module led_prescaler #(
  parameter int unsigned DIV   = 2700000,
  parameter int unsigned CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CntLast);

  // Counter wraps to zero on the tick cycle; nothing else touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern generator: Johnson, ring, bounce and hold modes stepped by a prescaler tick,
// with parallel load and step/wrap status pulses.
// Optional PWM dimming is built when LED_PATTERN_DIM_EN is defined.
module led_pattern_shifter
  import led_pattern_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIV    = 2700000,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DUTY_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pattern_shifter_if.slave  bus
);

  localparam logic [WIDTH-1:0] PatOrigin = WIDTH'(1);

  logic             tick;
  logic             do_step;
  logic             pat_onehot;
  logic [WIDTH-1:0] pat_q, pat_d, next_pat;
  logic             bdir_q, bdir_d, next_bdir;
  logic             next_wrap;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  led_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign pat_onehot = $onehot(pat_q);

  // Candidate next pattern for the current mode/direction, used only when a step happens.
  always_comb begin
    next_pat  = pat_q;
    next_bdir = bdir_q;
    unique case (bus.mode)
      MODE_JOHNSON: begin
        if (bus.dir == DIR_UP) begin
          next_pat = {pat_q[WIDTH-2:0], ~pat_q[WIDTH-1]};
        end else begin
          next_pat = {~pat_q[0], pat_q[WIDTH-1:1]};
        end
      end
      MODE_RING: begin
        if (pat_q == '0) begin
          next_pat = PatOrigin;
        end else if (bus.dir == DIR_UP) begin
          next_pat = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end else begin
          next_pat = {pat_q[0], pat_q[WIDTH-1:1]};
        end
      end
      MODE_BOUNCE: begin
        if (!pat_onehot) begin
          next_pat  = PatOrigin;
          next_bdir = DIR_UP;
        end else if (bdir_q == DIR_UP) begin
          if (pat_q[WIDTH-1]) begin
            // Loaded at the top while heading up: turn around rather than fall off.
            next_pat  = pat_q >> 1;
            next_bdir = DIR_DOWN;
          end else begin
            next_pat  = pat_q << 1;
            next_bdir = pat_q[WIDTH-2] ? DIR_DOWN : DIR_UP;
          end
        end else begin
          if (pat_q[0]) begin
            next_pat  = pat_q << 1;
            next_bdir = DIR_UP;
          end else begin
            next_pat  = pat_q >> 1;
            next_bdir = pat_q[1] ? DIR_UP : DIR_DOWN;
          end
        end
      end
      MODE_HOLD: begin
        next_pat  = pat_q;
        next_bdir = bdir_q;
      end
    endcase
  end

  // Phase origin is all-zero for Johnson and the LSB for ring/bounce.
  always_comb begin
    next_wrap = (bus.mode == MODE_JOHNSON) ? (next_pat == '0) : (next_pat == PatOrigin);
  end

  // Load wins over a coincident tick and swallows it; otherwise a qualified tick steps.
  always_comb begin
    do_step = tick & bus.en & is_step_mode(bus.mode) & ~bus.load;
    pat_d   = pat_q;
    bdir_d  = bdir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      pat_d  = bus.load_val;
      bdir_d = DIR_UP;
    end else if (do_step) begin
      pat_d  = next_pat;
      bdir_d = next_bdir;
      step_d = 1'b1;
      wrap_d = next_wrap;
    end
  end

  // Pattern, bounce direction and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      bdir_q <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      bdir_q <= bdir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

`ifdef LED_PATTERN_DIM_EN
  logic [DUTY_W-1:0] pwm_cnt_q;

  // Free-running PWM phase; LEDs are lit while the phase is below duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
    end
  end

  assign bus.led = pat_q & {WIDTH{pwm_cnt_q < bus.duty}};
`else
  logic [DUTY_W-1:0] duty_unused;

  assign duty_unused = bus.duty;
  assign bus.led     = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Self-checking bench for led_pattern_shifter (WIDTH=4, DIV=4, DUTY_W=4).
// Honours LED_PATTERN_DIM_EN when the same macro is defined for the DUT.
module tb_led_pattern_shifter;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DUTY_W = 4;

  logic clk;
  logic rst_n;

  led_pattern_shifter_if #(.WIDTH(WIDTH), .DUTY_W(DUTY_W)) bus ();

  led_pattern_shifter #(
    .WIDTH  (WIDTH),
    .DIV    (DIV),
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pattern is kept as an integer 0..15; bounce is tracked as a lit position plus a heading.
  int m_cyc, m_pat, m_up, m_step, m_wrap;
  int nx_pat, nx_up, nx_wrap;
  int m_led;

  function automatic int johnson_next(input int p, input int d);
    if (d == 0) return (p * 2) % 16 + ((p >= 8) ? 0 : 1);
    return p / 2 + ((p % 2 == 1) ? 0 : 8);
  endfunction

  function automatic int ring_next(input int p, input int d);
    if (p == 0) return 1;
    if (d == 0) return (p * 2) % 16 + p / 8;
    return p / 2 + (p % 2) * 8;
  endfunction

  always_comb begin
    int pos;
    pos     = 0;
    nx_pat  = m_pat;
    nx_up   = m_up;
    case (int'(bus.mode))
      0: nx_pat = johnson_next(m_pat, int'(bus.dir));
      1: nx_pat = ring_next(m_pat, int'(bus.dir));
      2: begin
        if (!(m_pat inside {1, 2, 4, 8})) begin
          nx_pat = 1;
          nx_up  = 1;
        end else begin
          pos = $clog2(m_pat);
          if (m_up != 0) begin
            if (pos == 3) begin
              pos   = 2;
              nx_up = 0;
            end else begin
              pos   = pos + 1;
              nx_up = (pos != 3) ? 1 : 0;
            end
          end else begin
            if (pos == 0) begin
              pos   = 1;
              nx_up = 1;
            end else begin
              pos   = pos - 1;
              nx_up = (pos == 0) ? 1 : 0;
            end
          end
          nx_pat = 1 << pos;
        end
      end
      default: nx_pat = m_pat;
    endcase
    nx_wrap = (int'(bus.mode) == 0) ? int'(nx_pat == 0) : int'(nx_pat == 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_pat  <= 0;
      m_up   <= 1;
      m_step <= 0;
      m_wrap <= 0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_step <= 0;
      m_wrap <= 0;
      if (bus.load) begin
        m_pat <= int'(bus.load_val);
        m_up  <= 1;
      end else if ((m_cyc % DIV) == DIV - 1 && bus.en && bus.mode != 2'b11) begin
        m_pat  <= nx_pat;
        m_up   <= nx_up;
        m_step <= 1;
        m_wrap <= nx_wrap;
      end
    end
  end

`ifdef LED_PATTERN_DIM_EN
  assign m_led = ((m_cyc % 16) < int'(bus.duty)) ? m_pat : 0;
`else
  assign m_led = m_pat;
`endif

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_led",  32'(bus.led),  32'(m_led));
      chk("model_step", 32'(bus.step), 32'(m_step));
      chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    while (n < 64) begin
      cyc();
      n++;
      if (bus.step) return;
    end
    miscompares++;
    $display("FAIL step_timeout: no step within 64 cycles, expected one");
  endtask

  task automatic expect_step(input string name, input int exp_led, input int exp_wrap);
    int n;
    wait_step(n);
    chk({name, "_led"},  32'(bus.led),  32'(exp_led));
    chk({name, "_wrap"}, 32'(bus.wrap), 32'(exp_wrap));
  endtask

  task automatic do_load(input int val);
    bus.load     = 1'b1;
    bus.load_val = WIDTH'(val);
    cyc();
    bus.load     = 1'b0;
  endtask

  int j_seq [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
  int r_seq [4] = '{8, 4, 2, 1};
  int b_seq [7] = '{1, 2, 4, 8, 4, 2, 1};

  initial begin
    int n;
    int steps;
    int on_cnt;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 2'b00;
    bus.dir      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.duty     = 4'd15;
    #23;
    chk("reset_led",  32'(bus.led),  32'h0);
    chk("reset_step", 32'(bus.step), 32'h0);
    cyc();
    rst_n  = 1'b1;
    bus.en = 1'b1;
    wait_step(n);
    chk("first_step_latency", 32'(n), 32'd4);

    // Johnson, dir up: first step already seen above.
`ifndef LED_PATTERN_DIM_EN
    chk("johnson0_led", 32'(bus.led), 32'(j_seq[0]));
`endif
    chk("johnson0_wrap", 32'(bus.wrap), 32'h0);
    for (int i = 1; i < 8; i++) begin
`ifndef LED_PATTERN_DIM_EN
      expect_step($sformatf("johnson%0d", i), j_seq[i], (i == 7) ? 1 : 0);
`else
      wait_step(n);
`endif
    end
    wait_step(n);
    chk("johnson_interval", 32'(n), 32'd4);

`ifndef LED_PATTERN_DIM_EN
    // Reset mid-sweep: outputs clear before any clock edge.
    wait_step(n);
    chk("presweep_led", 32'(bus.led), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_led",  32'(bus.led),  32'h0);
    chk("async_reset_step", 32'(bus.step), 32'h0);
    chk("async_reset_wrap", 32'(bus.wrap), 32'h0);
    cyc();
    rst_n = 1'b1;
    wait_step(n);
    chk("post_reset_latency", 32'(n), 32'd4);
    chk("post_reset_led", 32'(bus.led), 32'h1);

    // Ring, dir down, after loading the origin.
    bus.mode = 2'b01;
    bus.dir  = 1'b1;
    do_load(1);
    chk("load_led", 32'(bus.led), 32'h1);
    for (int i = 0; i < 4; i++) expect_step($sformatf("ring%0d", i), r_seq[i], (i == 3) ? 1 : 0);
    do_load(0);
    expect_step("ring_from_zero", 1, 1);

    // Bounce from all-zero, then recover from a non-one-hot load.
    bus.mode = 2'b10;
    do_load(0);
    for (int i = 0; i < 7; i++) begin
      expect_step($sformatf("bounce%0d", i), b_seq[i], (i == 0 || i == 6) ? 1 : 0);
    end
    do_load(6);
    expect_step("bounce_recover", 1, 1);

    // en low: ticks are discarded.
    bus.en = 1'b0;
    steps  = 0;
    repeat (12) begin
      cyc();
      if (bus.step) steps++;
    end
    chk("en_low_steps", 32'(steps), 32'd0);
    chk("en_low_led",   32'(bus.led), 32'h1);

    // Load on a tick cycle consumes the tick.
    bus.en   = 1'b1;
    bus.mode = 2'b01;
    bus.dir  = 1'b0;
    wait_step(n);
    repeat (3) cyc();
    bus.load     = 1'b1;
    bus.load_val = 4'b1010;
    cyc();
    bus.load = 1'b0;
    chk("load_tick_led",  32'(bus.led),  32'ha);
    chk("load_tick_step", 32'(bus.step), 32'h0);
    wait_step(n);
    chk("load_tick_next_latency", 32'(n), 32'd4);
    chk("load_tick_next_led", 32'(bus.led), 32'h5);

    // Hold: frozen pattern, no pulses.
    bus.mode = 2'b11;
    steps    = 0;
    repeat (12) begin
      cyc();
      if (bus.step) steps++;
    end
    chk("hold_steps", 32'(steps), 32'd0);
    chk("hold_led",   32'(bus.led), 32'h5);
`else
    // PWM dimming with a full pattern held.
    bus.mode = 2'b11;
    do_load(15);
    bus.duty = 4'd8;
    on_cnt   = 0;
    repeat (32) begin
      cyc();
      if (bus.led == 4'hf) on_cnt++;
    end
    chk("pwm_duty8_on", 32'(on_cnt), 32'd16);
    bus.duty = 4'd0;
    on_cnt   = 0;
    repeat (32) begin
      cyc();
      if (bus.led != 4'h0) on_cnt++;
    end
    chk("pwm_duty0_on", 32'(on_cnt), 32'd0);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
